// File: rtl/if_stage_param.sv
// Parametrised instruction-fetch stage: PC register, word-addressed program memory,
// jump/branch redirect and a registered IF/ID output with stall, flush and fault flags.
module if_stage_param #(
  parameter int unsigned             ADDR_W     = 32,
  parameter int unsigned             DATA_W     = 32,
  parameter int unsigned             IMEM_DEPTH = 64,
  parameter logic [ADDR_W-1:0]       RESET_PC   = '0,
  parameter logic [DATA_W-1:0]       NOP_WORD   = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          branch_taken,
  input  logic [ADDR_W-1:0]             branch_target,
  input  logic                          jump,
  input  logic [ADDR_W-1:0]             jump_target,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [DATA_W-1:0]             prog_data,
  output logic [ADDR_W-1:0]             pc,
  output logic                          id_valid,
  output logic [DATA_W-1:0]             id_instr,
  output logic [ADDR_W-1:0]             id_pc,
  output logic [ADDR_W-1:0]             id_pc_plus4,
  output logic [1:0]                    id_fault
);

  localparam int unsigned IDX_W = $clog2(IMEM_DEPTH);

  logic [DATA_W-1:0] mem [IMEM_DEPTH];

  logic [IDX_W-1:0]  fetch_idx;
  logic              range_fault;
  logic              write_hit;
  logic [DATA_W-1:0] fetch_word;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] pc_next;
  logic              misalign_q;

  assign fetch_idx   = pc[IDX_W+1:2];
  assign range_fault = {2'b00, pc[ADDR_W-1:2]} >= ADDR_W'(IMEM_DEPTH);
  // A write to the word being fetched on the same edge is forwarded straight into IF/ID.
  assign write_hit   = prog_we && (prog_addr == fetch_idx) && !range_fault;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fetch_word = mem[fetch_idx];
    if (range_fault) begin
      fetch_word = NOP_WORD;
    end else if (write_hit) begin
      fetch_word = prog_data;
    end
  end

  assign redirect        = jump | branch_taken;
  assign redirect_target = jump ? jump_target : branch_target;
  assign pc_plus4        = pc + ADDR_W'(4);

  always_comb begin
    pc_next = pc_plus4;
    if (redirect) begin
      pc_next = {redirect_target[ADDR_W-1:2], 2'b00};
    end else if (stall) begin
      pc_next = pc;
    end
  end

  // NOTE: program memory has no reset branch; contents survive reset and map onto plain RAM.
  always_ff @(posedge clock) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc <= pc_next;
      // The flag follows the target until its first instruction is latched normally.
      if (redirect) begin
        misalign_q <= |redirect_target[1:0];
      end else if (!flush && !stall) begin
        misalign_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_valid    <= 1'b0;
      id_instr    <= NOP_WORD;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
      id_fault    <= 2'b00;
    end else if (flush || redirect) begin
      id_valid    <= 1'b0;
      id_instr    <= NOP_WORD;
      id_pc       <= pc;
      id_pc_plus4 <= pc_plus4;
      id_fault    <= 2'b00;
    end else if (!stall) begin
      id_valid    <= 1'b1;
      id_instr    <= fetch_word;
      id_pc       <= pc;
      id_pc_plus4 <= pc_plus4;
      id_fault    <= {misalign_q, range_fault};
    end
  end

endmodule

// File: tb/tb_if_stage_param.sv
// Self-checking bench for if_stage_param: directed vectors with literal expectations plus
// a per-cycle comparison against a behavioural fetch model.
module tb_if_stage_param;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 64;
  localparam logic [31:0] NOP    = 32'h0;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [1:0]  id_fault;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  if_stage_param #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IMEM_DEPTH(DEPTH), .RESET_PC(32'h0), .NOP_WORD(NOP)
  ) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .pc(pc), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .id_fault(id_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] pattern(input int i);
    case (i)
      0:       return 32'h2008_0020;
      1:       return 32'h2009_0037;
      2:       return 32'h0109_8020;
      3:       return 32'h0109_8822;
      default: return 32'hC000_0000 | (32'(i) << 8) | 32'(i);
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: fetch address arithmetic straight from the fetch rules.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc, m_instr, m_idpc, m_idpc4, m_fetched, m_tgt;
  logic        m_valid, m_flag;
  logic [1:0]  m_fault;
  int unsigned m_idx;

  always @(posedge clock) begin
    if (prog_we) m_mem[prog_addr] = prog_data;
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pc = 32'h0; m_flag = 1'b0; m_valid = 1'b0; m_instr = NOP;
      m_idpc = 32'h0; m_idpc4 = 32'h0; m_fault = 2'b00;
    end else begin
      m_idx = m_pc / 4;
      if (m_idx >= DEPTH) m_fetched = NOP;
      else if (prog_we && int'(prog_addr) == m_idx) m_fetched = prog_data;
      else m_fetched = m_mem[m_idx];
      if (jump || branch_taken || flush) begin
        m_valid = 1'b0; m_instr = NOP; m_idpc = m_pc; m_idpc4 = m_pc + 32'd4; m_fault = 2'b00;
      end else if (!stall) begin
        m_valid = 1'b1; m_instr = m_fetched; m_idpc = m_pc; m_idpc4 = m_pc + 32'd4;
        m_fault = {m_flag, m_idx >= DEPTH};
        m_flag = 1'b0;
      end
      if (jump || branch_taken) begin
        m_tgt  = jump ? jump_target : branch_target;
        m_flag = (m_tgt % 4) != 0;
        m_pc   = m_tgt - (m_tgt % 4);
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(posedge clock) begin
    #2;
    if (cmp_en && !reset) begin
      check("model pc", pc, m_pc);
      check("model id_valid", id_valid, m_valid);
      check("model id_instr", id_instr, m_instr);
      check("model id_pc", id_pc, m_idpc);
      check("model id_pc_plus4", id_pc_plus4, m_idpc4);
      check("model id_fault", id_fault, m_fault);
    end
  end

  task automatic go();
    @(posedge clock);
    #3;
  endtask

  task automatic idle();
    stall = 0; flush = 0; branch_taken = 0; jump = 0; prog_we = 0;
  endtask

  task automatic check_held(input string name);
    check({name, " pc"}, pc, 32'h10);
    check({name, " id_valid"}, id_valid, 1'b0);
    check({name, " id_pc"}, id_pc, 32'h40);
    check({name, " id_instr"}, id_instr, NOP);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    branch_target = '0; jump_target = '0; prog_addr = '0; prog_data = '0;
    // Load the whole memory while reset is held.
    for (int i = 0; i < int'(DEPTH); i++) begin
      prog_we = 1; prog_addr = 6'(i); prog_data = pattern(i);
      go();
    end
    prog_we = 0;
    check("reset pc", pc, 32'h0);
    check("reset id_valid", id_valid, 1'b0);
    check("reset id_instr", id_instr, NOP);
    check("reset id_pc", id_pc, 32'h0);
    check("reset id_pc_plus4", id_pc_plus4, 32'h0);
    check("reset id_fault", id_fault, 2'b00);
    reset = 0;
    cmp_en = 1;

    // Sequential fetch of words 0..3.
    for (int i = 0; i < 4; i++) begin
      go();
      check("seq id_valid", id_valid, 1'b1);
      check("seq id_pc", id_pc, 32'(i * 4));
      check("seq id_instr", id_instr, pattern(i));
    end
    check("seq id_pc_plus4", id_pc_plus4, 32'd16);

    // Jump back to 8, then a branch from pc 8 to 0x18.
    jump = 1; jump_target = 32'h8; go(); jump = 0;
    check("jmp8 pc", pc, 32'h8);
    branch_taken = 1; branch_target = 32'h18; go(); branch_taken = 0;
    check("br bubble id_valid", id_valid, 1'b0);
    check("br bubble id_instr", id_instr, NOP);
    check("br pc", pc, 32'h18);
    go();
    check("br id_valid", id_valid, 1'b1);
    check("br id_pc", id_pc, 32'h18);
    check("br id_instr", id_instr, pattern(6));

    // Jump wins over a simultaneous branch.
    jump = 1; jump_target = 32'h3C; branch_taken = 1; branch_target = 32'h18; go(); idle();
    check("prio pc", pc, 32'h3C);
    check("prio id_valid", id_valid, 1'b0);
    go();
    check("prio id_pc", id_pc, 32'h3C);
    check("prio id_instr", id_instr, pattern(15));

    // Stall three cycles at pc 0x10; redirect lands even though stall follows.
    jump = 1; jump_target = 32'h10; go(); jump = 0;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      go();
      check_held("stall");
    end
    stall = 0; go();
    check("unstall id_pc", id_pc, 32'h10);
    check("unstall id_instr", id_instr, pattern(4));
    check("unstall id_valid", id_valid, 1'b1);

    // Stall with flush: squash wins, pc holds.
    stall = 1; flush = 1; go(); idle();
    check("stflush id_valid", id_valid, 1'b0);
    check("stflush pc", pc, 32'h14);
    go();
    check("stflush after id_pc", id_pc, 32'h14);

    // Misaligned and out-of-range target.
    jump = 1; jump_target = 32'h102; go(); jump = 0;
    check("mis pc", pc, 32'h100);
    go();
    check("mis id_fault", id_fault, 2'b11);
    check("mis id_instr", id_instr, NOP);
    check("mis id_valid", id_valid, 1'b1);
    go();
    check("range-only id_fault", id_fault, 2'b01);

    // Misaligned in-range branch.
    branch_taken = 1; branch_target = 32'h1A; go(); branch_taken = 0;
    check("mis2 pc", pc, 32'h18);
    go();
    check("mis2 id_fault", id_fault, 2'b10);
    check("mis2 id_instr", id_instr, pattern(6));
    go();
    check("mis2 clear id_fault", id_fault, 2'b00);

    // Wrap from the top of the address space.
    jump = 1; jump_target = 32'hFFFF_FFFC; go(); jump = 0;
    go();
    check("wrap id_pc", id_pc, 32'hFFFF_FFFC);
    check("wrap id_pc_plus4", id_pc_plus4, 32'h0);
    check("wrap pc", pc, 32'h0);
    go();
    check("wrap mem0", id_instr, pattern(0));

    // Write-first forwarding into the word being fetched.
    prog_we = 1; prog_addr = 6'd1; prog_data = 32'hDEAD_BEEF; go(); prog_we = 0;
    check("wfirst id_instr", id_instr, 32'hDEAD_BEEF);
    check("wfirst id_pc", id_pc, 32'h4);

    // Flush alone squashes but lets the pc advance.
    flush = 1; go(); flush = 0;
    check("flush id_valid", id_valid, 1'b0);
    check("flush pc", pc, 32'hC);

    // Asynchronous reset in the middle of a cycle.
    jump = 1; jump_target = 32'h20; go(); jump = 0;
    check("pre-reset pc", pc, 32'h20);
    #2 reset = 1;
    #1;
    check("async pc", pc, 32'h0);
    check("async id_valid", id_valid, 1'b0);
    check("async id_instr", id_instr, NOP);
    check("async id_pc", id_pc, 32'h0);
    check("async id_fault", id_fault, 2'b00);
    go();
    reset = 0;
    go();
    check("restart id_pc", id_pc, 32'h0);
    check("restart id_instr", id_instr, pattern(0));
    check("restart pc", pc, 32'h4);
    go();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
